// File: rtl/circuito_decodificador_pkg.sv
// circuito_decodificador_pkg: FSM states, function codes and code-to-one-hot decode.
package circuito_decodificador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } estado_t;

    localparam logic [2:0] COD_NONE = 3'b000;
    localparam logic [2:0] COD_A    = 3'b001;
    localparam logic [2:0] COD_B    = 3'b010;
    localparam logic [2:0] COD_C    = 3'b011;
    localparam logic [2:0] COD_D    = 3'b100;
    localparam logic [2:0] COD_E    = 3'b101;
    localparam logic [2:0] COD_F    = 3'b110;
    localparam logic [2:0] COD_G    = 3'b111;

    // A lands on bit 6, G on bit 0
    function automatic logic [6:0] decodifica(input logic [2:0] cod);
        return (cod == COD_NONE) ? 7'd0 : 7'b1000000 >> (cod - 3'd1);
    endfunction

endpackage

// File: rtl/circuito_decodificador_funcionalidade_contador_ciclos.sv
// contador_ciclos: up counter with synchronous clear, enable and terminal-count flag.
module contador_ciclos #(
    parameter int           W      = 4,
    parameter logic [W-1:0] LIMITE = '0
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt;

    // clear together with enable counts the current cycle as the first one
    always_ff @(posedge clk)
        cnt <= clr ? W'(en) : en ? cnt + W'(1) : cnt;

    assign tc = cnt == LIMITE;

endmodule

// File: rtl/circuito_decodificador_funcionalidade.sv
// circuito_decodificador_funcionalidade: qualified function-code decoder driving a one-hot select.
// Define DECOD_TIMEOUT_EN to add the ACTIVE hold timeout and the TIMEOUT pulse.
module circuito_decodificador_funcionalidade
    import circuito_decodificador_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int HOLD_MAX      = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] CF,
    input  logic       CF_VALID,
    input  logic       ACK,
    output logic [6:0] SEL,
    output logic       BUSY,
    output logic       DONE,
    output logic       TIMEOUT
);

    estado_t    estado, estado_nxt;
    logic [2:0] cod, cod_nxt;
    logic       valido, igual, stab_tc, hold_tc, fim_ack;
    logic       stab_clr, stab_en;

    assign valido  = CF_VALID && CF != COD_NONE;
    assign igual   = CF == cod;
    assign fim_ack = estado == ACTIVE && ACK;
    assign BUSY    = estado != IDLE;

    always_comb begin
        estado_nxt = estado;
        cod_nxt    = cod;
        case (estado)
            IDLE:
                if (valido) begin
                    cod_nxt    = CF;
                    estado_nxt = stab_tc ? ACTIVE : QUALIFY;
                end
            QUALIFY:
                if (!valido)
                    estado_nxt = IDLE;
                else if (!igual)
                    cod_nxt = CF;
                else if (stab_tc)
                    estado_nxt = ACTIVE;
            ACTIVE:
                estado_nxt = (ACK || hold_tc) ? RELEASE : ACTIVE;
            RELEASE:
                estado_nxt = CF_VALID ? RELEASE : IDLE;
            default:
                estado_nxt = IDLE;
        endcase
    end

    // count sits at 0 outside QUALIFY, so its flag compares against STABLE_CYCLES-1
    assign stab_clr = !rst_n || estado != QUALIFY || !valido || !igual;
    assign stab_en  = rst_n && valido && (estado == IDLE || estado == QUALIFY);

    contador_ciclos #(
        .W      (4),
        .LIMITE (4'(STABLE_CYCLES - 1))
    ) u_estab (
        .clk (clk),
        .clr (stab_clr),
        .en  (stab_en),
        .tc  (stab_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= IDLE;
            cod    <= COD_NONE;
            SEL    <= '0;
            DONE   <= 1'b0;
        end else begin
            estado <= estado_nxt;
            cod    <= cod_nxt;
            SEL    <= (estado_nxt == ACTIVE) ? decodifica(cod_nxt) : 7'd0;
            DONE   <= fim_ack;
        end
    end

`ifdef DECOD_TIMEOUT_EN
    logic hold_clr, hold_en;

    assign hold_clr = !rst_n || estado != ACTIVE;
    assign hold_en  = rst_n && estado == ACTIVE;

    contador_ciclos #(
        .W      (8),
        .LIMITE (8'(HOLD_MAX - 1))
    ) u_hold (
        .clk (clk),
        .clr (hold_clr),
        .en  (hold_en),
        .tc  (hold_tc)
    );

    // ACK wins over a simultaneous timeout
    always_ff @(posedge clk)
        TIMEOUT <= !rst_n ? 1'b0 : (estado == ACTIVE && !ACK && hold_tc);
`else
    assign hold_tc = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_circuito_decodificador_funcionalidade.sv
// tb_circuito_decodificador_funcionalidade: directed vector table plus timeout/reset corner sequences.
module tb_circuito_decodificador_funcionalidade;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cf = 3'd0;
    logic       cf_valid = 1'b0;
    logic       ack = 1'b0;
    logic [6:0] sel;
    logic       busy, done, timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       r;
        logic [2:0] c;
        logic       v;
        logic       a;
        logic [6:0] sel;
        logic       busy;
        logic       done;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    circuito_decodificador_funcionalidade #(
        .STABLE_CYCLES (4),
        .HOLD_MAX      (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .CF       (cf),
        .CF_VALID (cf_valid),
        .ACK      (ack),
        .SEL      (sel),
        .BUSY     (busy),
        .DONE     (done),
        .TIMEOUT  (timeout)
    );

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] s, input logic b, input logic d, input logic t);
        chk({tag, " sel"}, sel, s);
        chk({tag, " busy"}, {6'd0, busy}, {6'd0, b});
        chk({tag, " done"}, {6'd0, done}, {6'd0, d});
        chk({tag, " timeout"}, {6'd0, timeout}, {6'd0, t});
    endtask

    task automatic step(input logic r, input logic [2:0] c, input logic v, input logic a);
        rst_n    = r;
        cf       = c;
        cf_valid = v;
        ack      = a;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [2:0] c, input logic v, input logic a,
                       input logic [6:0] s, input logic b, input logic d, input logic t);
        vec_t x;
        x.r = r; x.c = c; x.v = v; x.a = a;
        x.sel = s; x.busy = b; x.done = d; x.to = t;
        vecs.push_back(x);
    endtask

    initial begin
        // reset
        add(0, 3'b000, 0, 0, 7'b0000000, 0, 0, 0);
        // C held four edges, CF ignored in ACTIVE, ACK ends it
        add(1, 3'b011, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b011, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b011, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b011, 1, 0, 7'b0010000, 1, 0, 0);
        add(1, 3'b000, 0, 0, 7'b0010000, 1, 0, 0);
        add(1, 3'b000, 0, 1, 7'b0000000, 1, 1, 0);
        add(1, 3'b000, 0, 0, 7'b0000000, 0, 0, 0);
        // E twice then F four times: only F is selected, after the 6th edge
        add(1, 3'b101, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b101, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b110, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b110, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b110, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b110, 1, 0, 7'b0000010, 1, 0, 0);
        add(1, 3'b000, 0, 1, 7'b0000000, 1, 1, 0);
        add(1, 3'b000, 0, 0, 7'b0000000, 0, 0, 0);
        // valid dropped after three edges; code 000 and stray ACK in IDLE
        add(1, 3'b001, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b001, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b001, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b001, 0, 0, 7'b0000000, 0, 0, 0);
        add(1, 3'b000, 1, 0, 7'b0000000, 0, 0, 0);
        add(1, 3'b000, 0, 1, 7'b0000000, 0, 0, 0);
        // reset while A is active, then ACK ignored
        add(1, 3'b001, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b001, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b001, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b001, 1, 0, 7'b1000000, 1, 0, 0);
        add(0, 3'b001, 1, 0, 7'b0000000, 0, 0, 0);
        add(1, 3'b000, 0, 1, 7'b0000000, 0, 0, 0);
        // G acked while still held: RELEASE persists, no retrigger
        add(1, 3'b111, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b111, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b111, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b111, 1, 0, 7'b0000001, 1, 0, 0);
        add(1, 3'b111, 1, 1, 7'b0000000, 1, 1, 0);
        add(1, 3'b111, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b111, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b111, 1, 0, 7'b0000000, 1, 0, 0);
        add(1, 3'b111, 0, 0, 7'b0000000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].a);
            chk_all($sformatf("v%0d", i), vecs[i].sel, vecs[i].busy, vecs[i].done, vecs[i].to);
        end

        // ACK never asserted while C is held
        for (int i = 0; i < 3; i++) step(1, 3'b011, 1, 0);
        step(1, 3'b011, 1, 0);
        chk_all("hold entry", 7'b0010000, 1, 0, 0);
`ifdef DECOD_TIMEOUT_EN
        for (int k = 1; k < 10; k++) begin
            step(1, 3'b011, 1, 0);
            chk_all($sformatf("hold k%0d", k), 7'b0010000, 1, 0, 0);
        end
        step(1, 3'b011, 1, 0);
        chk_all("timeout edge", 7'b0000000, 1, 0, 1);
        step(1, 3'b011, 1, 0);
        chk_all("timeout release", 7'b0000000, 1, 0, 0);
        step(1, 3'b011, 1, 0);
        chk_all("timeout no retrigger", 7'b0000000, 1, 0, 0);
`else
        for (int k = 1; k <= 20; k++) begin
            step(1, 3'b011, 1, 0);
            chk_all($sformatf("hold k%0d", k), 7'b0010000, 1, 0, 0);
        end
        step(1, 3'b011, 1, 1);
        chk_all("late ack", 7'b0000000, 1, 1, 0);
`endif
        step(1, 3'b000, 0, 0);
        chk_all("hold idle", 7'b0000000, 0, 0, 0);

        // ACK on the exact timeout edge resolves as ACK
        for (int i = 0; i < 4; i++) step(1, 3'b010, 1, 0);
        chk_all("race entry", 7'b0100000, 1, 0, 0);
        for (int k = 1; k < 10; k++) step(1, 3'b010, 0, 0);
        chk_all("race before", 7'b0100000, 1, 0, 0);
        step(1, 3'b010, 0, 1);
        chk_all("race edge", 7'b0000000, 1, 1, 0);
        step(1, 3'b000, 0, 0);
        chk_all("race after", 7'b0000000, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/circuito_decodificador_funcionalidade.md
CIRCUITO_DECODIFICADOR_FUNCIONALIDADE -- requirements
Module: circuito_decodificador_funcionalidade

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive cycles a nonzero code must be held valid before acceptance (legal range 1..15).
REQ-002 Parameter HOLD_MAX, default 255, SHALL set the ACTIVE-state timeout in cycles (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 CF  input  3  function code: 001=A, 010=B, 011=C, 100=D, 101=E, 110=F, 111=G, 000=none.
REQ-006 CF_VALID  input  1  CF is meaningful this cycle.
REQ-007 ACK  input  1  the selected function has completed.
REQ-008 SEL  output  7  registered one-hot function select; SEL[6]=A ... SEL[0]=G.
REQ-009 BUSY  output  1  high in every state except IDLE.
REQ-010 DONE  output  1  one-cycle pulse on ACK acceptance.
REQ-011 TIMEOUT  output  1  one-cycle pulse on ACTIVE timeout.

Function
REQ-012 The FSM SHALL have states IDLE, QUALIFY, ACTIVE and RELEASE.
REQ-013 In IDLE, CF_VALID=1 with CF!=000 SHALL capture CF and set the stability count to 1; CF=000 or CF_VALID=0 SHALL keep the FSM in IDLE.
REQ-014 Each edge with CF_VALID=1 and CF equal to the captured code SHALL increment the count; when the count reaches STABLE_CYCLES the FSM SHALL enter ACTIVE on that same edge (STABLE_CYCLES=1: directly from IDLE).
REQ-015 In QUALIFY, a different nonzero valid code SHALL recapture it with count 1; CF_VALID=0 or CF=000 SHALL return the FSM to IDLE.
REQ-016 SEL SHALL be nonzero only in ACTIVE, with exactly the bit decoded from the captured code set; latency from first sampled valid edge to SEL high is STABLE_CYCLES edges.
REQ-017 In ACTIVE, CF changes SHALL be ignored; ACK=1 SHALL clear SEL, pulse DONE for one cycle and enter RELEASE on the same edge.
REQ-018 In ACTIVE, a hold counter SHALL start at 0 on entry; when it reaches HOLD_MAX with ACK=0, SEL SHALL clear, TIMEOUT SHALL pulse for one cycle and the FSM SHALL enter RELEASE.
REQ-019 ACK and timeout on the same edge SHALL resolve as ACK (DONE pulses, TIMEOUT stays 0).
REQ-020 ACK outside ACTIVE SHALL be ignored.
REQ-021 RELEASE SHALL persist while CF_VALID=1 and return to IDLE on the first edge with CF_VALID=0, so a held code cannot retrigger.
REQ-022 DONE and TIMEOUT SHALL never be high simultaneously and never for more than one cycle.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, SEL=0, BUSY=0, DONE=0, TIMEOUT=0 and clear both counters and the captured code, from any state including ACTIVE.
REQ-024 The first edge after rst_n returns high SHALL be evaluated as IDLE.

Configuration
REQ-025 With macro DECOD_TIMEOUT_EN defined, the hold counter and REQ-018/019 SHALL be implemented.
REQ-026 Without DECOD_TIMEOUT_EN, ACTIVE SHALL persist until ACK or reset, TIMEOUT SHALL be constant 0 and no hold counter SHALL be synthesized.

Structure
REQ-027 Package circuito_decodificador_pkg SHALL hold the state enum, the seven code constants (COD_A..COD_G, COD_NONE) and the code-to-one-hot decode function.
REQ-028 One sub-module contador_ciclos (parameterized width, synchronous clear, enable, terminal-count flag) SHALL implement both the stability and the hold counters.

Verification
REQ-029 STABLE_CYCLES=4: CF=011, CF_VALID=1 for 4 edges -> SEL=0010000 after edge 4, BUSY=1; ACK=1 one cycle -> SEL=0, DONE=1 one cycle.
REQ-030 CF=101 valid 2 edges, then CF=110 valid 4 edges -> SEL=0000010 only after the 6th edge; SEL never equals E's bit.
REQ-031 CF_VALID dropped after 3 of 4 edges -> FSM back to IDLE, SEL=0, BUSY=0; CF=000 with valid -> no state change.
REQ-032 DECOD_TIMEOUT_EN, HOLD_MAX=10, ACK never asserted -> TIMEOUT pulses once 10 cycles after SEL rises, SEL=0; CF_VALID held 1 keeps RELEASE, no retrigger until CF_VALID=0.
REQ-033 ACK asserted on the exact timeout edge -> DONE=1, TIMEOUT=0.
REQ-034 rst_n=0 during ACTIVE with SEL=1000000 -> all outputs 0 on next edge; ACK after reset ignored.
